// File: rtl/exec_mem_reg_if.sv
// Execute-to-memory bundle: execute-side inputs, memory-side outputs
// and the forwarding port back to the execute operand muxes.
// master: execute/environment side, slave: the pipeline register.
interface exec_mem_reg_if #(
    parameter int REG_SIZE = 32,
    parameter int REG_ADDR = 5
);
    logic                ex_valid;
    logic [REG_SIZE-1:0] ex_alu_out;
    logic                ex_overflow;
    logic                ex_zero;
    logic                ex_ovf_trap;
    logic [REG_SIZE-1:0] ex_store_data;
    logic [REG_ADDR-1:0] ex_rd;
    logic                ex_regwrite;
    logic                ex_memread;
    logic                ex_memwrite;
    logic                ex_byte;
    logic [REG_SIZE-1:0] ex_pc;

    logic                mem_valid;
    logic [REG_SIZE-1:0] mem_alu_out;
    logic                mem_zero;
    logic [REG_SIZE-1:0] mem_store_data;
    logic [REG_ADDR-1:0] mem_rd;
    logic                mem_regwrite;
    logic                mem_memread;
    logic                mem_memwrite;
    logic                mem_byte;
    logic [REG_SIZE-1:0] mem_pc;
    logic                mem_exc;
    logic [1:0]          mem_exc_code;
    logic                exc_pending;

    logic                fwd_en;
    logic [REG_ADDR-1:0] fwd_rd;
    logic [REG_SIZE-1:0] fwd_val;

    modport master (
        output ex_valid, ex_alu_out, ex_overflow, ex_zero, ex_ovf_trap,
        output ex_store_data, ex_rd, ex_regwrite, ex_memread,
        output ex_memwrite, ex_byte, ex_pc,
        input  mem_valid, mem_alu_out, mem_zero, mem_store_data, mem_rd,
        input  mem_regwrite, mem_memread, mem_memwrite, mem_byte, mem_pc,
        input  mem_exc, mem_exc_code, exc_pending,
        input  fwd_en, fwd_rd, fwd_val
    );

    modport slave (
        input  ex_valid, ex_alu_out, ex_overflow, ex_zero, ex_ovf_trap,
        input  ex_store_data, ex_rd, ex_regwrite, ex_memread,
        input  ex_memwrite, ex_byte, ex_pc,
        output mem_valid, mem_alu_out, mem_zero, mem_store_data, mem_rd,
        output mem_regwrite, mem_memread, mem_memwrite, mem_byte, mem_pc,
        output mem_exc, mem_exc_code, exc_pending,
        output fwd_en, fwd_rd, fwd_val
    );
endinterface

// File: rtl/exec_mem_reg.sv
// EX/MEM pipeline register with stall, flush, exception capture and
// forwarding port. Ports: clk, reset (async high), stall, flush, bus.
module exec_mem_reg #(
    parameter int REG_SIZE = 32,
    parameter int REG_ADDR = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    exec_mem_reg_if.slave bus
);
    logic                valid_q;
    logic [REG_SIZE-1:0] alu_q;
    logic                zero_q;
    logic [REG_SIZE-1:0] sd_q;
    logic [REG_ADDR-1:0] rd_q;
    logic                rw_q;
    logic                mr_q;
    logic                mw_q;
    logic                byte_q;
    logic [REG_SIZE-1:0] pc_q;
    logic                exc_q;
    logic [1:0]          code_q;
    logic                pend_q;

    logic                accept;
    logic                misal;
    logic [1:0]          code_d;

    assign accept = bus.ex_valid & ~pend_q;
    // Byte accesses can never be misaligned.
    assign misal  = ~bus.ex_byte & (bus.ex_alu_out[1:0] != 2'b00);

    // Overflow outranks misalignment; load outranks store.
    always_comb begin
        code_d = 2'd0;
        if (bus.ex_overflow & bus.ex_ovf_trap)
            code_d = 2'd1;
        else if (bus.ex_memread & misal)
            code_d = 2'd2;
        else if (bus.ex_memwrite & misal)
            code_d = 2'd3;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            zero_q  <= 1'b0;
            sd_q    <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            byte_q  <= 1'b0;
            pc_q    <= '0;
            exc_q   <= 1'b0;
            code_q  <= 2'd0;
            pend_q  <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            exc_q   <= 1'b0;
            code_q  <= 2'd0;
            pend_q  <= 1'b0;
        end else if (!stall) begin
            alu_q  <= bus.ex_alu_out;
            zero_q <= bus.ex_zero;
            sd_q   <= bus.ex_store_data;
            rd_q   <= bus.ex_rd;
            byte_q <= bus.ex_byte;
            pc_q   <= bus.ex_pc;
            if (accept) begin
                // A faulting instruction stays valid but loses its
                // side effects; younger ones are squashed until flush.
                valid_q <= 1'b1;
                exc_q   <= (code_d != 2'd0);
                code_q  <= code_d;
                pend_q  <= (code_d != 2'd0);
                rw_q    <= bus.ex_regwrite & (code_d == 2'd0);
                mr_q    <= bus.ex_memread  & (code_d == 2'd0);
                mw_q    <= bus.ex_memwrite & (code_d == 2'd0);
            end else begin
                valid_q <= 1'b0;
                exc_q   <= 1'b0;
                code_q  <= 2'd0;
                rw_q    <= 1'b0;
                mr_q    <= 1'b0;
                mw_q    <= 1'b0;
            end
        end
    end

    assign bus.mem_valid      = valid_q;
    assign bus.mem_alu_out    = alu_q;
    assign bus.mem_zero       = zero_q;
    assign bus.mem_store_data = sd_q;
    assign bus.mem_rd         = rd_q;
    assign bus.mem_regwrite   = rw_q;
    assign bus.mem_memread    = mr_q;
    assign bus.mem_memwrite   = mw_q;
    assign bus.mem_byte       = byte_q;
    assign bus.mem_pc         = pc_q;
    assign bus.mem_exc        = exc_q;
    assign bus.mem_exc_code   = code_q;
    assign bus.exc_pending    = pend_q;

    assign bus.fwd_en  = valid_q & rw_q & (rd_q != '0);
    assign bus.fwd_rd  = rd_q;
    assign bus.fwd_val = alu_q;
endmodule

// File: tb/tb_exec_mem_reg.sv
// Randomized and directed bench for exec_mem_reg against a
// rule-level reference model of the EX/MEM register.
module tb_exec_mem_reg;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;
    logic flush = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    exec_mem_reg_if #(.REG_SIZE(32), .REG_ADDR(5)) bus ();

    exec_mem_reg #(.REG_SIZE(32), .REG_ADDR(5)) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // reference state
    bit          m_valid, m_zero, m_rw, m_mr, m_mw, m_byte, m_exc, m_pend;
    int unsigned m_alu, m_sd, m_pc, m_rd, m_code;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_zero = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        m_byte = 0; m_exc = 0; m_pend = 0;
        m_alu = 0; m_sd = 0; m_pc = 0; m_rd = 0; m_code = 0;
    endtask

    task automatic model_edge();
        int unsigned c;
        if (flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
            m_exc = 0; m_code = 0; m_pend = 0;
        end else if (!stall) begin
            if (bus.ex_valid && !m_pend) begin
                c = 0;
                if (bus.ex_overflow && bus.ex_ovf_trap) c = 1;
                else if (bus.ex_memread && !bus.ex_byte && bus.ex_alu_out % 4 != 0) c = 2;
                else if (bus.ex_memwrite && !bus.ex_byte && bus.ex_alu_out % 4 != 0) c = 3;
                m_valid = 1;
                m_alu = bus.ex_alu_out; m_zero = bus.ex_zero;
                m_sd = bus.ex_store_data; m_rd = bus.ex_rd;
                m_byte = bus.ex_byte; m_pc = bus.ex_pc;
                m_code = c; m_exc = (c != 0); m_pend = (c != 0);
                m_rw = bus.ex_regwrite && c == 0;
                m_mr = bus.ex_memread && c == 0;
                m_mw = bus.ex_memwrite && c == 0;
            end else begin
                m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
                m_exc = 0; m_code = 0;
            end
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".valid"}, bus.mem_valid, m_valid);
        check({tag, ".rw"}, bus.mem_regwrite, m_rw);
        check({tag, ".mr"}, bus.mem_memread, m_mr);
        check({tag, ".mw"}, bus.mem_memwrite, m_mw);
        check({tag, ".exc"}, bus.mem_exc, m_exc);
        check({tag, ".code"}, bus.mem_exc_code, m_code);
        check({tag, ".pend"}, bus.exc_pending, m_pend);
        check({tag, ".fwd_en"}, bus.fwd_en, m_valid && m_rw && m_rd != 0);
        if (m_valid) begin
            check({tag, ".alu"}, bus.mem_alu_out, m_alu);
            check({tag, ".zero"}, bus.mem_zero, m_zero);
            check({tag, ".sd"}, bus.mem_store_data, m_sd);
            check({tag, ".rd"}, bus.mem_rd, m_rd);
            check({tag, ".byte"}, bus.mem_byte, m_byte);
            check({tag, ".pc"}, bus.mem_pc, m_pc);
            check({tag, ".fwd_rd"}, bus.fwd_rd, m_rd);
            check({tag, ".fwd_val"}, bus.fwd_val, m_alu);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, bus.mem_valid, 0);
        check({tag, ".alu"}, bus.mem_alu_out, 0);
        check({tag, ".zero"}, bus.mem_zero, 0);
        check({tag, ".sd"}, bus.mem_store_data, 0);
        check({tag, ".rd"}, bus.mem_rd, 0);
        check({tag, ".ctl"}, {bus.mem_regwrite, bus.mem_memread,
                              bus.mem_memwrite, bus.mem_byte}, 0);
        check({tag, ".pc"}, bus.mem_pc, 0);
        check({tag, ".exc"}, {bus.mem_exc, bus.mem_exc_code,
                              bus.exc_pending}, 0);
        check({tag, ".fwd_en"}, bus.fwd_en, 0);
    endtask

    task automatic set_ins(input bit v, input int unsigned alu,
                           input bit ovf, input bit trap, input int unsigned rd,
                           input bit rw, input bit mr, input bit mw,
                           input bit by, input int unsigned pc);
        bus.ex_valid = v; bus.ex_alu_out = alu;
        bus.ex_overflow = ovf; bus.ex_ovf_trap = trap;
        bus.ex_zero = (alu == 0);
        bus.ex_store_data = $urandom;
        bus.ex_rd = rd[4:0]; bus.ex_regwrite = rw;
        bus.ex_memread = mr; bus.ex_memwrite = mw;
        bus.ex_byte = by; bus.ex_pc = pc;
    endtask

    task automatic rand_ins();
        set_ins($urandom_range(3, 0) != 0, $urandom, $urandom_range(1, 0),
                $urandom_range(7, 0) == 0, $urandom_range(31, 0),
                $urandom_range(1, 0), $urandom_range(3, 0) == 0,
                $urandom_range(3, 0) == 0, $urandom_range(1, 0),
                $urandom & 32'hFFFF_FFFC);
    endtask

    // One clock: model follows the edge, outputs compared 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare(tag);
    endtask

    initial begin
        set_ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // accepted add, then rd=0
        set_ins(1, 32'h10, 0, 0, 3, 1, 0, 0, 0, 32'h4);
        step("add");
        check("add.fwd_en1", bus.fwd_en, 1);
        set_ins(1, 32'h10, 0, 0, 0, 1, 0, 0, 0, 32'h8);
        step("add_rd0");
        check("add.fwd_en0", bus.fwd_en, 0);

        // untrapped overflow writes normally
        set_ins(1, 32'h8000_0000, 1, 0, 7, 1, 0, 0, 0, 32'hC);
        step("ovf_notrap");

        // overflow trap then squashed instructions
        set_ins(1, 32'h8000_0000, 1, 1, 9, 1, 0, 0, 0, 32'h40);
        step("ovf_trap");
        check("trap.code", bus.mem_exc_code, 1);
        check("trap.pc", bus.mem_pc, 32'h40);
        for (int i = 0; i < 3; i++) begin
            set_ins(1, 32'h100 + i, 0, 0, 4, 1, 0, 0, 0, 32'h44 + 4 * i);
            step("squash");
            check("squash.valid", bus.mem_valid, 0);
        end
        stall = 1'b1; flush = 1'b1;
        step("flush_stall");
        stall = 1'b0; flush = 1'b0;

        // misaligned word store, then byte store
        set_ins(1, 32'h1002, 0, 0, 0, 0, 0, 1, 0, 32'h50);
        step("st_misal");
        check("st_misal.code", bus.mem_exc_code, 3);
        flush = 1'b1;
        step("flush");
        flush = 1'b0;
        set_ins(1, 32'h1003, 0, 0, 0, 0, 0, 1, 1, 32'h54);
        step("st_byte");
        check("st_byte.mw", bus.mem_memwrite, 1);
        set_ins(1, 32'h2001, 0, 0, 5, 1, 1, 0, 0, 32'h58);
        step("ld_misal");

        // stall with pending exception, then flush while stalled
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ins();
            step("stall");
        end
        flush = 1'b1;
        step("stall_flush");
        check("stall_flush.pend", bus.exc_pending, 0);
        stall = 1'b0;

        // flush beats a trapping input
        set_ins(1, 32'h7FFF_FFFF, 1, 1, 2, 1, 0, 0, 0, 32'h60);
        step("flush_trap");
        flush = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rand_ins();
            flush = $urandom_range(m_pend ? 3 : 15, 0) == 0;
            stall = $urandom_range(5, 0) == 0;
            step("rand");
        end
        flush = 1'b0; stall = 1'b0;

        // async reset between edges
        set_ins(1, 32'h1234_5678, 0, 0, 6, 1, 0, 0, 0, 32'h70);
        step("pre_reset");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        set_ins(1, 32'h20, 0, 0, 8, 1, 0, 0, 0, 32'h74);
        step("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/exec_mem_reg.md
Name: exec_mem_reg

Overview:
- Pipeline register between the execute stage (ALU) and the memory stage.
- Captures the ALU result, overflow/zero flags, store data and control bits each cycle.
- Supports stall (hold) and flush (bubble).
- Detects arithmetic-overflow and misaligned-access exceptions, then suppresses younger instructions until the pipeline is flushed.
- Drives a forwarding port back to the execute operand muxes.

Parameters:
REG_SIZE, 32, datapath width (matches `REG_SIZE)
REG_ADDR, 5, register index width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
stall  input  1  hold all state this cycle
flush  input  1  load a bubble and clear exception-pending
ex_valid  input  1  execute stage holds a real instruction
ex_alu_out  input  REG_SIZE  ALU result or effective address
ex_overflow  input  1  ALU overflow flag
ex_zero  input  1  ALU zero flag
ex_ovf_trap  input  1  instruction traps on overflow (signed add/sub)
ex_store_data  input  REG_SIZE  rt value for stores
ex_rd  input  REG_ADDR  destination register
ex_regwrite  input  1  writes register file
ex_memread  input  1  load
ex_memwrite  input  1  store
ex_byte  input  1  1 = byte access, 0 = word access
ex_pc  input  REG_SIZE  instruction PC
mem_valid  output  1  registered valid
mem_alu_out  output  REG_SIZE  registered result/address
mem_zero  output  1  registered zero flag
mem_store_data  output  REG_SIZE  registered store data
mem_rd  output  REG_ADDR  registered destination
mem_regwrite  output  1  registered, exception-gated
mem_memread  output  1  registered, exception-gated
mem_memwrite  output  1  registered, exception-gated
mem_byte  output  1  registered access size
mem_pc  output  REG_SIZE  registered PC
mem_exc  output  1  exception on the held instruction
mem_exc_code  output  2  0 none, 1 overflow, 2 misaligned load, 3 misaligned store
exc_pending  output  1  exception latched and not yet flushed
fwd_en  output  1  combinational: mem_valid & mem_regwrite & (mem_rd != 0)
fwd_rd  output  REG_ADDR  combinational: mem_rd
fwd_val  output  REG_SIZE  combinational: mem_alu_out

Behaviour:
- Reset (async): all registered outputs 0 and exc_pending 0; a bubble with no exception.
- Priority on a clock edge: reset > flush > stall > load.
- flush: clears valid, regwrite, memread, memwrite, mem_exc, mem_exc_code and exc_pending. Data fields may hold any value and are not checked.
- stall (no flush): every register, including exc_pending, holds its value.
- Load: the instruction is accepted when ex_valid=1 and exc_pending=0.
  - Accepted instruction: all fields copied with one-cycle latency.
  - Not accepted: loads a bubble (valid and control bits 0, exc 0).
- Exception detection applies to accepted instructions only, in priority order:
  - ex_overflow & ex_ovf_trap gives code 1.
  - ex_memread & !ex_byte & (ex_alu_out[1:0] != 0) gives code 2.
  - ex_memwrite & !ex_byte & (ex_alu_out[1:0] != 0) gives code 3.
  - Byte accesses never misalign.
- On an exception:
  - mem_exc=1 and mem_valid=1.
  - mem_regwrite, mem_memread and mem_memwrite are forced to 0, so no architectural side effect occurs.
  - mem_pc holds the faulting PC.
  - exc_pending is set on the same edge.
- While exc_pending=1, every incoming instruction becomes a bubble until flush. exc_pending has no other clear path.
- Simultaneous flush and exception-causing input: flush wins; nothing is latched and exc_pending=0.
- Simultaneous stall and flush: flush wins.
- ex_overflow without ex_ovf_trap (unsigned ops): no exception, and the result is written normally.
- Forwarding outputs are purely combinational from the registered state; there is no internal bypass.

Test Plan:
1. Reset mid-stream with reset=1 asynchronously between edges -> all outputs 0 immediately, before the next clock edge.
2. Accepted add: ex_alu_out=0x00000010, rd=3, regwrite=1 -> next cycle mem_alu_out=0x10, mem_rd=3, fwd_en=1. Repeat with rd=0 -> fwd_en=0.
3. Overflow trap: src 0x7FFFFFFF+1 with ex_overflow=1 and ex_ovf_trap=1, pc=0x40 -> mem_exc=1, code=1, mem_pc=0x40, mem_regwrite=0, exc_pending=1. Next three valid inputs -> mem_valid=0.
4. Misaligned word store at address 0x1002 -> code 3, mem_memwrite=0. Byte store at 0x1003 -> no exception, mem_memwrite=1.
5. Stall for 3 cycles with changing inputs -> outputs frozen. Then flush with stall=1 -> bubble loaded, exc_pending=0.
6. Flush in the same cycle as an overflow-trapping input -> mem_valid=0, mem_exc=0, exc_pending=0.
